// File: rtl/topo_pkg.sv
// topo_pkg: shared definitions for the whack-a-mole playfield.
//   cell_state_t : per-cell state encoding (EMPTY/UP/STRUCK)
//   RGB_*        : 3-bit cell colours {R,G,B}
//   idx_width()  : clog2 with a minimum of one bit
package topo_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    UP     = 2'd1,
    STRUCK = 2'd2
  } cell_state_t;

  localparam logic [2:0] RGB_VERDE    = 3'b010;
  localparam logic [2:0] RGB_AZUL     = 3'b001;
  localparam logic [2:0] RGB_AMARILLO = 3'b110;
  localparam logic [2:0] RGB_ROJO     = 3'b100;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/topo_grid_if.sv
// topo_grid_if: game-side signal bundle of the playfield.
//   master : game controller / stimulus (drives TICK, spawn, moves, GOLPE)
//   slave  : topo_grid (drives HIT, MISS, SCORE, MISSES, CURSOR, ACTIVE, RGB)
interface topo_grid_if
  import topo_pkg::*;
#(
  parameter int unsigned ROWS    = 3,
  parameter int unsigned COLS    = 3,
  parameter int unsigned LIFE_W  = 8,
  parameter int unsigned SCORE_W = 8
);
  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = idx_width(N);

  logic               TICK;
  logic               PONER_TOPO;
  logic [IDX_W-1:0]   TOPO_IDX;
  logic [LIFE_W-1:0]  TOPO_LIFE;
  logic               MOVE_UP;
  logic               MOVE_DOWN;
  logic               MOVE_LEFT;
  logic               MOVE_RIGHT;
  logic               GOLPE;
  logic               HIT;
  logic               MISS;
  logic [SCORE_W-1:0] SCORE;
  logic [SCORE_W-1:0] MISSES;
  logic [IDX_W-1:0]   CURSOR;
  logic [N-1:0]       ACTIVE;
  logic [3*N-1:0]     RGB;

  modport master (
    output TICK, PONER_TOPO, TOPO_IDX, TOPO_LIFE,
           MOVE_UP, MOVE_DOWN, MOVE_LEFT, MOVE_RIGHT, GOLPE,
    input  HIT, MISS, SCORE, MISSES, CURSOR, ACTIVE, RGB
  );

  modport slave (
    input  TICK, PONER_TOPO, TOPO_IDX, TOPO_LIFE,
           MOVE_UP, MOVE_DOWN, MOVE_LEFT, MOVE_RIGHT, GOLPE,
    output HIT, MISS, SCORE, MISSES, CURSOR, ACTIVE, RGB
  );

endinterface

// File: rtl/topo_cell.sv
// topo_cell: one mole cell -- EMPTY/UP/STRUCK state machine, lifetime/flash
// counter and colour mux.
//   clk, rst_n : clock, async active-low reset
//   tick       : game-time enable for the counter
//   spawn      : spawn request addressed to this cell
//   life       : lifetime loaded on spawn (0 is treated as 1)
//   strike     : GOLPE with the cursor on this cell
//   selected   : cursor is on this cell (colour only)
//   active     : cell is UP
//   hit        : strike lands this cycle (combinational)
//   expire     : mole times out unstruck this cycle (combinational)
//   rgb        : cell colour
module topo_cell
  import topo_pkg::*;
#(
  parameter int unsigned LIFE_W      = 8,
  parameter int unsigned FLASH_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              spawn,
  input  logic [LIFE_W-1:0] life,
  input  logic              strike,
  input  logic              selected,
  output logic              active,
  output logic              hit,
  output logic              expire,
  output logic [2:0]        rgb
);

  localparam logic [LIFE_W-1:0] CNT_ONE   = LIFE_W'(1);
  localparam logic [LIFE_W-1:0] CNT_FLASH = LIFE_W'(FLASH_TICKS);

  cell_state_t       state_q, state_d;
  logic [LIFE_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    expire  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (spawn) begin
          state_d = UP;
          cnt_d   = (life == '0) ? CNT_ONE : life;
        end
      end
      UP: begin
        // a strike on the expiry cycle counts as a hit
        if (strike) begin
          state_d = STRUCK;
          cnt_d   = CNT_FLASH;
          hit     = 1'b1;
        end else if (tick) begin
          if (cnt_q == CNT_ONE) begin
            state_d = EMPTY;
            cnt_d   = '0;
            expire  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      STRUCK: begin
        if (tick) begin
          if (cnt_q == CNT_ONE) begin
            state_d = EMPTY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

  assign active = (state_q == UP);

  always_comb begin
    rgb = RGB_VERDE;
    if (selected) begin
      rgb = RGB_AZUL;
    end else begin
      case (state_q)
        STRUCK:  rgb = RGB_ROJO;
        UP:      rgb = RGB_AMARILLO;
        default: rgb = RGB_VERDE;
      endcase
    end
  end

endmodule

// File: rtl/topo_grid.sv
// topo_grid: ROWS x COLS whack-a-mole playfield. Owns the cursor, the
// registered HIT/MISS pulses and the saturating SCORE/MISSES counters;
// instantiates one topo_cell per grid position.
//   Clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : topo_grid_if.slave (game inputs in, status/colours out)
// Optional: define TOPO_CURSOR_WRAP_EN for toroidal cursor wrap at the grid
// edges; otherwise the cursor saturates at the edges.
module topo_grid
  import topo_pkg::*;
#(
  parameter int unsigned ROWS        = 3,
  parameter int unsigned COLS        = 3,
  parameter int unsigned LIFE_W      = 8,
  parameter int unsigned FLASH_TICKS = 4,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic       Clock,
  input  logic       reset,
  topo_grid_if.slave bus
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = idx_width(N);
  localparam int unsigned ROW_W = idx_width(ROWS);
  localparam int unsigned COL_W = idx_width(COLS);
  localparam int unsigned CNT_W = idx_width(N + 1);
  localparam int unsigned SUM_W = SCORE_W + CNT_W;

  localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(COLS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [IDX_W-1:0]   cursor;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] misses_q, misses_d;
  logic [CNT_W-1:0]   n_exp;
  logic [SUM_W-1:0]   misses_sum;

  logic [N-1:0]       hit_vec, exp_vec, active_vec;
  logic [3*N-1:0]     rgb_vec;

  assign cursor = IDX_W'(int'(row_q) * COLS + int'(col_q));

  for (genvar i = 0; i < N; i++) begin : g_cell
    topo_cell #(
      .LIFE_W      (LIFE_W),
      .FLASH_TICKS (FLASH_TICKS)
    ) u_cell (
      .clk      (Clock),
      .rst_n    (reset),
      .tick     (bus.TICK),
      .spawn    (bus.PONER_TOPO && (bus.TOPO_IDX == IDX_W'(i))),
      .life     (bus.TOPO_LIFE),
      .strike   (bus.GOLPE && (cursor == IDX_W'(i))),
      .selected (cursor == IDX_W'(i)),
      .active   (active_vec[i]),
      .hit      (hit_vec[i]),
      .expire   (exp_vec[i]),
      .rgb      (rgb_vec[3*i +: 3])
    );
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      row_q    <= '0;
      col_q    <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      score_q  <= '0;
      misses_q <= '0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      score_q  <= score_d;
      misses_q <= misses_d;
    end
  end

  // Cursor: one move per cycle, UP > DOWN > LEFT > RIGHT. A blocked move at
  // an edge is dropped rather than falling through to a lower priority one.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (bus.MOVE_UP) begin
      if (row_q != '0) row_d = row_q - ROW_W'(1);
`ifdef TOPO_CURSOR_WRAP_EN
      else row_d = ROW_LAST;
`endif
    end else if (bus.MOVE_DOWN) begin
      if (row_q != ROW_LAST) row_d = row_q + ROW_W'(1);
`ifdef TOPO_CURSOR_WRAP_EN
      else row_d = '0;
`endif
    end else if (bus.MOVE_LEFT) begin
      if (col_q != '0) col_d = col_q - COL_W'(1);
`ifdef TOPO_CURSOR_WRAP_EN
      else col_d = COL_LAST;
`endif
    end else if (bus.MOVE_RIGHT) begin
      if (col_q != COL_LAST) col_d = col_q + COL_W'(1);
`ifdef TOPO_CURSOR_WRAP_EN
      else col_d = '0;
`endif
    end
  end

  // Several cells may expire together: MISS pulses once, MISSES adds them all.
  always_comb begin
    n_exp = '0;
    for (int unsigned k = 0; k < N; k++) begin
      n_exp = n_exp + CNT_W'(exp_vec[k]);
    end
    hit_d      = |hit_vec;
    miss_d     = |exp_vec;
    misses_sum = SUM_W'(misses_q) + SUM_W'(n_exp);
    misses_d   = (misses_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : misses_sum[SCORE_W-1:0];
    score_d    = (hit_d && (score_q != SCORE_MAX)) ? score_q + SCORE_W'(1) : score_q;
  end

  assign bus.HIT    = hit_q;
  assign bus.MISS   = miss_q;
  assign bus.SCORE  = score_q;
  assign bus.MISSES = misses_q;
  assign bus.CURSOR = cursor;
  assign bus.ACTIVE = active_vec;
  assign bus.RGB    = rgb_vec;

endmodule

// File: tb/tb_topo_grid.sv
// tb_topo_grid: self-checking bench for topo_grid (3x3 grid).
module tb_topo_grid;

  localparam int ROWS    = 3;
  localparam int COLS    = 3;
  localparam int N       = ROWS * COLS;
  localparam int LIFE_W  = 8;
  localparam int FLASH   = 4;
  localparam int SCORE_W = 8;
  localparam int IDX_W   = 4;
  localparam int SMAX    = 255;
`ifdef TOPO_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int C18 = WRAP ? 6 : 0;

  logic Clock = 1'b0;
  logic reset = 1'b0;

  topo_grid_if #(.ROWS(ROWS), .COLS(COLS), .LIFE_W(LIFE_W), .SCORE_W(SCORE_W)) bus ();

  topo_grid #(
    .ROWS(ROWS), .COLS(COLS), .LIFE_W(LIFE_W), .FLASH_TICKS(FLASH), .SCORE_W(SCORE_W)
  ) dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a mole is "up" while life_m>0, "flashing" while flash_m>0.
  int life_m [N];
  int flash_m[N];
  int row_m, col_m;
  int score_m, misses_m;
  bit hit_m, miss_m;

  typedef struct {
    logic       tick;
    logic       sp;
    int         idx;
    int         life;
    logic [3:0] mv;     // {up, down, left, right}
    logic       g;
    logic       e_hit;
    logic       e_miss;
    int         e_score;
    int         e_misses;
    int         e_cursor;
    logic [8:0] e_active;
    logic [2:0] e_c4;   // colour of cell 4
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic tk, sp, input int idx, lf, input logic [3:0] mv,
                              input logic g, input logic eh, em, input int es, ems, ec,
                              input logic [8:0] ea, input logic [2:0] c4);
    vec_t v;
    v.tick = tk; v.sp = sp; v.idx = idx; v.life = lf; v.mv = mv; v.g = g;
    v.e_hit = eh; v.e_miss = em; v.e_score = es; v.e_misses = ems; v.e_cursor = ec;
    v.e_active = ea; v.e_c4 = c4;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      life_m[i] = 0;
      flash_m[i] = 0;
    end
    row_m = 0; col_m = 0; score_m = 0; misses_m = 0; hit_m = 0; miss_m = 0;
  endfunction

  function automatic void model_step(input logic tk, sp, input int idx, lf,
                                     input logic [3:0] mv, input logic g);
    int cur = row_m * COLS + col_m;
    int nh = 0;
    int ne = 0;
    for (int i = 0; i < N; i++) begin
      if (flash_m[i] > 0) begin
        if (tk) flash_m[i]--;
      end else if (life_m[i] > 0) begin
        if (g && cur == i) begin
          life_m[i] = 0;
          flash_m[i] = FLASH;
          nh++;
        end else if (tk) begin
          life_m[i]--;
          if (life_m[i] == 0) ne++;
        end
      end else if (sp && idx == i) begin
        life_m[i] = (lf == 0) ? 1 : lf;
      end
    end
    if (mv[3])      row_m = (row_m > 0) ? row_m - 1 : (WRAP ? ROWS - 1 : row_m);
    else if (mv[2]) row_m = (row_m < ROWS - 1) ? row_m + 1 : (WRAP ? 0 : row_m);
    else if (mv[1]) col_m = (col_m > 0) ? col_m - 1 : (WRAP ? COLS - 1 : col_m);
    else if (mv[0]) col_m = (col_m < COLS - 1) ? col_m + 1 : (WRAP ? 0 : col_m);
    hit_m    = (nh > 0);
    miss_m   = (ne > 0);
    score_m  = (score_m + nh > SMAX) ? SMAX : score_m + nh;
    misses_m = (misses_m + ne > SMAX) ? SMAX : misses_m + ne;
  endfunction

  task automatic check_model();
    logic [8:0]  act_e;
    logic [26:0] rgb_e;
    int cur = row_m * COLS + col_m;
    for (int i = 0; i < N; i++) begin
      act_e[i] = (life_m[i] > 0);
      if (i == cur)          rgb_e[3*i +: 3] = 3'b001;
      else if (flash_m[i] > 0) rgb_e[3*i +: 3] = 3'b100;
      else if (life_m[i] > 0)  rgb_e[3*i +: 3] = 3'b110;
      else                     rgb_e[3*i +: 3] = 3'b010;
    end
    chk("model HIT",    32'(bus.HIT),    32'(hit_m));
    chk("model MISS",   32'(bus.MISS),   32'(miss_m));
    chk("model SCORE",  32'(bus.SCORE),  32'(score_m));
    chk("model MISSES", 32'(bus.MISSES), 32'(misses_m));
    chk("model CURSOR", 32'(bus.CURSOR), 32'(cur));
    chk("model ACTIVE", 32'(bus.ACTIVE), 32'(act_e));
    chk("model RGB",    32'(bus.RGB),    32'(rgb_e));
  endtask

  task automatic step(input logic tk, sp, input int idx, lf, input logic [3:0] mv, input logic g);
    bus.TICK       = tk;
    bus.PONER_TOPO = sp;
    bus.TOPO_IDX   = IDX_W'(idx);
    bus.TOPO_LIFE  = LIFE_W'(lf);
    bus.MOVE_UP    = mv[3];
    bus.MOVE_DOWN  = mv[2];
    bus.MOVE_LEFT  = mv[1];
    bus.MOVE_RIGHT = mv[0];
    bus.GOLPE      = g;
    @(posedge Clock);
    model_step(tk, sp, idx, lf, mv, g);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    bus.TICK = 0; bus.PONER_TOPO = 0; bus.TOPO_IDX = '0; bus.TOPO_LIFE = '0;
    bus.MOVE_UP = 0; bus.MOVE_DOWN = 0; bus.MOVE_LEFT = 0; bus.MOVE_RIGHT = 0;
    bus.GOLPE = 0;
  endtask

  task automatic goto(input int t);
    int tr = t / COLS;
    int tc = t % COLS;
    for (int k = 0; k < 8; k++) begin
      if (row_m > tr)      step(0, 0, 0, 0, 4'b1000, 0);
      else if (row_m < tr) step(0, 0, 0, 0, 4'b0100, 0);
      else if (col_m > tc) step(0, 0, 0, 0, 4'b0010, 0);
      else if (col_m < tc) step(0, 0, 0, 0, 4'b0001, 0);
    end
  endtask

  task automatic clear_flash();
    for (int k = 0; k < FLASH; k++) step(1, 0, 0, 0, 4'b0000, 0);
  endtask

  logic [26:0] rst_rgb;

  initial begin
    for (int i = 0; i < N; i++) rst_rgb[3*i +: 3] = (i == 0) ? 3'b001 : 3'b010;

    idle_inputs();
    model_reset();
    repeat (3) @(negedge Clock);
    reset = 1'b1;
    #1;
    check_model();

    // Mid-game asynchronous reset
    step(0, 1, 4, 9, 4'b0000, 0);
    step(0, 0, 0, 0, 4'b0100, 0);
    step(0, 0, 0, 0, 4'b0001, 0);
    step(0, 0, 0, 0, 4'b0000, 1);
    step(0, 1, 7, 5, 4'b0000, 0);
    idle_inputs();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst ACTIVE", 32'(bus.ACTIVE), 32'h0);
    chk("rst CURSOR", 32'(bus.CURSOR), 32'h0);
    chk("rst SCORE",  32'(bus.SCORE),  32'h0);
    chk("rst MISSES", 32'(bus.MISSES), 32'h0);
    chk("rst HIT",    32'(bus.HIT),    32'h0);
    chk("rst MISS",   32'(bus.MISS),   32'h0);
    chk("rst RGB",    32'(bus.RGB),    32'(rst_rgb));
    #1;
    reset = 1'b1;

    // Directed table
    add(0,1,4,3,4'b0000,0, 0,0,0,0,0, 9'h010, 3'd6);
    add(0,0,0,0,4'b0100,0, 0,0,0,0,3, 9'h010, 3'd6);
    add(0,0,0,0,4'b0001,0, 0,0,0,0,4, 9'h010, 3'd1);
    add(0,0,0,0,4'b0000,1, 1,0,1,0,4, 9'h000, 3'd1);
    add(0,0,0,0,4'b0010,0, 0,0,1,0,3, 9'h000, 3'd4);
    add(1,0,0,0,4'b0000,0, 0,0,1,0,3, 9'h000, 3'd4);
    add(1,0,0,0,4'b0000,0, 0,0,1,0,3, 9'h000, 3'd4);
    add(1,0,0,0,4'b0000,0, 0,0,1,0,3, 9'h000, 3'd4);
    add(1,0,0,0,4'b0000,0, 0,0,1,0,3, 9'h000, 3'd2);
    add(0,1,2,2,4'b0000,0, 0,0,1,0,3, 9'h004, 3'd2);
    add(1,0,0,0,4'b0000,0, 0,0,1,0,3, 9'h004, 3'd2);
    add(1,0,0,0,4'b0000,0, 0,1,1,1,3, 9'h000, 3'd2);
    add(0,0,0,0,4'b0000,0, 0,0,1,1,3, 9'h000, 3'd2);
    add(0,1,0,1,4'b0000,0, 0,0,1,1,3, 9'h001, 3'd2);
    add(0,1,1,1,4'b0000,0, 0,0,1,1,3, 9'h003, 3'd2);
    add(1,0,0,0,4'b0000,0, 0,1,1,3,3, 9'h000, 3'd2);
    add(0,0,0,0,4'b0000,0, 0,0,1,3,3, 9'h000, 3'd2);
    add(0,0,0,0,4'b1000,0, 0,0,1,3,0, 9'h000, 3'd2);
    add(0,0,0,0,4'b1010,0, 0,0,1,3,C18, 9'h000, 3'd2);
    add(0,1,12,5,4'b0000,0, 0,0,1,3,C18, 9'h000, 3'd2);
    add(0,1,4,0,4'b0000,0, 0,0,1,3,C18, 9'h010, 3'd6);
    add(1,0,0,0,4'b0000,0, 0,1,1,4,C18, 9'h000, 3'd2);
    add(0,0,0,0,4'b0000,0, 0,0,1,4,C18, 9'h000, 3'd2);

    foreach (tbl[k]) begin
      step(tbl[k].tick, tbl[k].sp, tbl[k].idx, tbl[k].life, tbl[k].mv, tbl[k].g);
      chk($sformatf("row%0d HIT", k),    32'(bus.HIT),        32'(tbl[k].e_hit));
      chk($sformatf("row%0d MISS", k),   32'(bus.MISS),       32'(tbl[k].e_miss));
      chk($sformatf("row%0d SCORE", k),  32'(bus.SCORE),      32'(tbl[k].e_score));
      chk($sformatf("row%0d MISSES", k), 32'(bus.MISSES),     32'(tbl[k].e_misses));
      chk($sformatf("row%0d CURSOR", k), 32'(bus.CURSOR),     32'(tbl[k].e_cursor));
      chk($sformatf("row%0d ACTIVE", k), 32'(bus.ACTIVE),     32'(tbl[k].e_active));
      chk($sformatf("row%0d RGB4", k),   32'(bus.RGB[14:12]), 32'(tbl[k].e_c4));
    end

    // Strike on the expiry cycle: hit wins
    goto(8);
    step(0, 1, 8, 1, 4'b0000, 0);
    step(1, 0, 0, 0, 4'b0000, 1);
    chk("expiry-strike HIT",  32'(bus.HIT),  32'h1);
    chk("expiry-strike MISS", 32'(bus.MISS), 32'h0);
    clear_flash();

    // Spawn and strike on the same empty cell: spawn only
    step(0, 1, 8, 5, 4'b0000, 1);
    chk("spawn-strike HIT",    32'(bus.HIT),       32'h0);
    chk("spawn-strike ACTIVE", 32'(bus.ACTIVE[8]), 32'h1);
    // Respawn on an up cell must not reload its lifetime
    step(0, 1, 8, 200, 4'b0000, 0);
    step(1, 0, 0, 0, 4'b0000, 0);
    step(1, 0, 0, 0, 4'b0000, 0);
    step(1, 0, 0, 0, 4'b0000, 0);
    step(1, 0, 0, 0, 4'b0000, 0);
    step(1, 0, 0, 0, 4'b0000, 0);
    chk("no-reload MISS", 32'(bus.MISS), 32'h1);

    // Drive SCORE to saturation
    for (int it = 0; it < 300 && score_m < SMAX; it++) begin
      step(0, 1, 8, 5, 4'b0000, 0);
      step(0, 0, 0, 0, 4'b0000, 1);
      clear_flash();
    end
    step(0, 1, 8, 5, 4'b0000, 0);
    step(0, 0, 0, 0, 4'b0000, 1);
    chk("sat HIT",   32'(bus.HIT),   32'h1);
    chk("sat SCORE", 32'(bus.SCORE), 32'd255);
    clear_flash();

    // Randomised play against the model
    for (int it = 0; it < 3000; it++) begin
      logic [3:0] mv;
      mv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
           mv, ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
